pe_driver: RTL

Sequencer that drives one processing element (PE) through a complete neuron evaluation and returns the result. It fetches coefficient and activation pairs from two dual-lane, 1-cycle-latency memories and issues the PE's set/bias/en operand protocol. It captures `nnout` on the exact cycle it is final and presents it upstream on a valid/ready handshake. It sits between the layer controller and the PE, one instance per PE.

---
 rtl/pe_drv_pkg.sv | 16 +
 rtl/pe_drv_addr_gen.sv | 46 ++++
 rtl/pe_driver.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pe_drv_pkg.sv
// Shared types and fixed-point/latency constants for the PE driver.
// Imported by pe_driver and pe_drv_addr_gen.
package pe_drv_pkg;
    localparam int FL_IN   = 7;   // activation fraction bits
    localparam int FL_WE   = 12;  // coefficient fraction bits
    localparam int PE_LAT  = 3;   // PE operand-to-accumulator latency
    localparam int MEM_LAT = 1;   // operand memory read latency

    typedef enum logic [2:0] {
        IDLE,
        SET,
        RUN,
        DRAIN,
        OUT
    } state_t;
endpackage

// File: rtl/pe_drv_addr_gen.sv
// Pair counter and operand memory read sequencing for the PE driver.
// Reads start on the SET cycle so data lands exactly in each RUN cycle.
module pe_drv_addr_gen
    import pe_drv_pkg::*;
#(
    parameter int LEN_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             launch,
    input  logic             run,
    input  logic [LEN_W-1:0] len,
    output logic             mem_rd,
    output logic [LEN_W-1:0] mem_addr,
    output logic             last_pair
);
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] pair_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q    <= '0;
            pair_cnt <= '0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
        end else if (launch) begin
            len_q    <= len;
            pair_cnt <= '0;
            mem_rd   <= (len != '0);
            mem_addr <= '0;
        end else begin
            // Strobe stays up for exactly len cycles: SET plus all but the last RUN cycle.
            if (mem_rd) begin
                if (mem_addr + LEN_W'(1) < len_q) begin
                    mem_addr <= mem_addr + LEN_W'(1);
                end else begin
                    mem_rd   <= 1'b0;
                    mem_addr <= '0;
                end
            end
            if (run) pair_cnt <= pair_cnt + LEN_W'(1);
        end
    end

    assign last_pair = run && (pair_cnt == len_q - LEN_W'(1));
endmodule

// File: rtl/pe_driver.sv
// Sequencer driving one PE through set/accumulate/drain and returning nnout.
// Optional PE_DRV_RELU_EN clamps negative results to zero at capture.
module pe_driver
    import pe_drv_pkg::*;
#(
    parameter int COFF_W = 16,
    parameter int NNIN_W = 16,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [COFF_W-1:0] bias_in,
    output logic              busy,
    output logic [LEN_W-1:0]  mem_addr,
    output logic              mem_rd,
    input  logic [COFF_W-1:0] coff_rdata1,
    input  logic [COFF_W-1:0] coff_rdata2,
    input  logic [NNIN_W-1:0] nnin_rdata1,
    input  logic [NNIN_W-1:0] nnin_rdata2,
    output logic              pe_set,
    output logic              pe_en,
    output logic [COFF_W-1:0] pe_bias,
    output logic [COFF_W-1:0] pe_coff1,
    output logic [COFF_W-1:0] pe_coff2,
    output logic [NNIN_W-1:0] pe_nnin1,
    output logic [NNIN_W-1:0] pe_nnin2,
    input  logic [NNIN_W-1:0] pe_nnout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [NNIN_W-1:0] res_data
);
    localparam int DW = $clog2(PE_LAT);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PE_LAT - 1);

    state_t            state;
    logic              len_zero;
    logic [DW-1:0]     drain_cnt;
    logic              launch;
    logic              last_pair;
    logic [NNIN_W-1:0] cap_val;

    assign launch = (state == IDLE) && start;

    pe_drv_addr_gen #(.LEN_W(LEN_W)) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .launch    (launch),
        .run       (state == RUN),
        .len       (len),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .last_pair (last_pair)
    );

    // pe_en is high exactly in RUN, so it doubles as the operand gate.
    assign pe_coff1 = pe_en ? coff_rdata1 : '0;
    assign pe_coff2 = pe_en ? coff_rdata2 : '0;
    assign pe_nnin1 = pe_en ? nnin_rdata1 : '0;
    assign pe_nnin2 = pe_en ? nnin_rdata2 : '0;

`ifdef PE_DRV_RELU_EN
    assign cap_val = pe_nnout[NNIN_W-1] ? '0 : pe_nnout;
`else
    assign cap_val = pe_nnout;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            len_zero  <= 1'b0;
            drain_cnt <= '0;
            pe_set    <= 1'b0;
            pe_en     <= 1'b0;
            pe_bias   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= SET;
                    busy     <= 1'b1;
                    len_zero <= (len == '0);
                    pe_set   <= 1'b1;
                    pe_bias  <= bias_in;
                end
                SET: begin
                    pe_set    <= 1'b0;
                    pe_bias   <= '0;
                    drain_cnt <= '0;
                    if (len_zero) begin
                        state <= DRAIN;
                    end else begin
                        state <= RUN;
                        pe_en <= 1'b1;
                    end
                end
                RUN: if (last_pair) begin
                    pe_en <= 1'b0;
                    state <= DRAIN;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + DW'(1);
                    // Last DRAIN edge coincides with the PE clearing its accumulator.
                    if (drain_cnt == DRAIN_LAST) begin
                        res_data  <= cap_val;
                        res_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: if (res_ready) begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
